// File: rtl/wb_stage_pkg.sv
// Shared core definitions: load funct3 encodings, error flag bit positions,
// and the write-back stage state/context types.
package wb_stage_pkg;

    // Load width/sign codes (funct3 field of RV32I loads)
    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

    // Sticky error flag bit positions
    localparam int unsigned ErrMisaligned  = 0;
    localparam int unsigned ErrUnsolicited = 1;
    localparam int unsigned ErrTimeout     = 2;
    localparam int unsigned ErrWidth       = 3;

    typedef enum logic {
        StIdle,
        StWaitMem
    } wb_state_e;

    // Fields of an accepted load that are needed when its response arrives
    typedef struct packed {
        logic       wb_en;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } load_ctx_t;

endpackage

// File: rtl/load_align.sv
// Load formatter: extracts the addressed byte/half/word from a raw memory
// word, applies sign or zero extension and reports misalignment.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by low address bits
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extension and alignment check; unlisted codes behave as a full word
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            Funct3Lb:  data = {{24{byte_sel[7]}}, byte_sel};
            Funct3Lbu: data = {24'h000000, byte_sel};
            Funct3Lh: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            Funct3Lhu: begin
                data       = {16'h0000, half_sel};
                misaligned = addr_lo[0];
            end
            default: begin
                data       = word;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results immediately, holds loads until the
// data memory responds (or times out), formats load data and drives the
// register file write port. Errors are reported in sticky flags.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_wb_en,
    input  logic                ex_is_load,
    input  logic [4:0]          ex_rd_addr,
    input  logic [31:0]         ex_result,
    input  logic [2:0]          ex_funct3,
    input  logic [1:0]          ex_addr_lo,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [31:0]         mem_rsp_data,
    output logic                regs_w_en,
    output logic [4:0]          rd_addr,
    output logic [31:0]         rd_data,
    output logic [ErrWidth-1:0] err_flags
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    wb_state_e  state_q;
    load_ctx_t  ld_ctx_q;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_inc;
    logic [31:0] fmt_data;
    logic        fmt_misaligned;

    load_align u_load_align (
        .word       (mem_rsp_data),
        .funct3     (ld_ctx_q.funct3),
        .addr_lo    (ld_ctx_q.addr_lo),
        .data       (fmt_data),
        .misaligned (fmt_misaligned)
    );

    assign ex_ready      = (state_q == StIdle);
    assign mem_rsp_ready = (state_q == StWaitMem);

    // Saturating increment of the response wait counter
    assign wait_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    // FSM with registered write port and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ld_ctx_q   <= '0;
            wait_cnt_q <= 8'd0;
            regs_w_en  <= 1'b0;
            rd_addr    <= 5'd0;
            rd_data    <= 32'd0;
            err_flags  <= '0;
        end else begin
            // Write strobe is a single-cycle pulse
            regs_w_en <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (mem_rsp_valid) begin
                        err_flags[ErrUnsolicited] <= 1'b1;
                    end
                    if (ex_valid) begin
                        if (ex_is_load) begin
                            ld_ctx_q.wb_en   <= ex_wb_en;
                            ld_ctx_q.rd      <= ex_rd_addr;
                            ld_ctx_q.funct3  <= ex_funct3;
                            ld_ctx_q.addr_lo <= ex_addr_lo;
                            wait_cnt_q       <= 8'd0;
                            state_q          <= StWaitMem;
                        end else if (ex_wb_en && (ex_rd_addr != 5'd0)) begin
                            // rd_addr/rd_data only move when a write happens
                            regs_w_en <= 1'b1;
                            rd_addr   <= ex_rd_addr;
                            rd_data   <= ex_result;
                        end
                    end
                end
                StWaitMem: begin
                    if (mem_rsp_valid) begin
                        // A response wins over a timeout landing in the same cycle
                        state_q <= StIdle;
                        if (fmt_misaligned) begin
                            err_flags[ErrMisaligned] <= 1'b1;
                        end else if (ld_ctx_q.wb_en && (ld_ctx_q.rd != 5'd0)) begin
                            regs_w_en <= 1'b1;
                            rd_addr   <= ld_ctx_q.rd;
                            rd_data   <= fmt_data;
                        end
                    end else begin
                        wait_cnt_q <= wait_inc;
                        if (wait_inc >= TimeoutLimit) begin
                            err_flags[ErrTimeout] <= 1'b1;
                            state_q               <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: transaction-level reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_wb_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_wb_en, ex_is_load;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        regs_w_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  err_flags;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_wb_en      (ex_wb_en),
        .ex_is_load    (ex_is_load),
        .ex_rd_addr    (ex_rd_addr),
        .ex_result     (ex_result),
        .ex_funct3     (ex_funct3),
        .ex_addr_lo    (ex_addr_lo),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .regs_w_en     (regs_w_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .err_flags     (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access size in bytes implied by a load code
    function automatic int ld_size(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic bit ld_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (int'(lo) % ld_size(f3)) != 0;
    endfunction

    // Shift the addressed lanes down, mask to size, extend unless unsigned
    function automatic logic [31:0] ld_format(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lo);
        int          sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz = ld_size(f3);
        if (sz == 4) return w;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = (w >> (8 * int'(lo))) & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model state
    bit          m_busy;
    int          m_waited;
    logic        m_ld_wb;
    logic [4:0]  m_ld_rd;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_ld_lo;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [2:0]  m_err;

    // Reference model: one pending load at most, writes appear one cycle later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_waited <= 0; m_ld_wb <= 0; m_ld_rd <= 0; m_ld_f3 <= 0;
            m_ld_lo <= 0; m_wen <= 0; m_rd <= 0; m_data <= 0; m_err <= 0;
        end else begin
            m_wen <= 0;
            if (!m_busy) begin
                if (mem_rsp_valid) m_err[1] <= 1'b1;
                if (ex_valid && ex_is_load) begin
                    m_busy <= 1; m_waited <= 0; m_ld_wb <= ex_wb_en; m_ld_rd <= ex_rd_addr;
                    m_ld_f3 <= ex_funct3; m_ld_lo <= ex_addr_lo;
                end else if (ex_valid && ex_wb_en && ex_rd_addr != 0) begin
                    m_wen <= 1; m_rd <= ex_rd_addr; m_data <= ex_result;
                end
            end else if (mem_rsp_valid) begin
                m_busy <= 0;
                if (ld_misaligned(m_ld_f3, m_ld_lo)) m_err[0] <= 1'b1;
                else if (m_ld_wb && m_ld_rd != 0) begin
                    m_wen <= 1; m_rd <= m_ld_rd;
                    m_data <= ld_format(mem_rsp_data, m_ld_f3, m_ld_lo);
                end
            end else if (m_waited + 1 >= TO) begin
                m_busy <= 0; m_err[2] <= 1'b1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp ex_ready", 32'(ex_ready), 32'(!m_busy));
            chk("cmp mem_rsp_ready", 32'(mem_rsp_ready), 32'(m_busy));
            chk("cmp regs_w_en", 32'(regs_w_en), 32'(m_wen));
            chk("cmp rd_addr", 32'(rd_addr), 32'(m_rd));
            chk("cmp rd_data", rd_data, m_data);
            chk("cmp err_flags", 32'(err_flags), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd_addr = 0; ex_result = 0;
        ex_funct3 = 0; ex_addr_lo = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    endtask

    task automatic issue(input logic load, input logic wb, input logic [4:0] rd,
                         input logic [31:0] res, input logic [2:0] f3, input logic [1:0] lo);
        ex_valid = 1; ex_is_load = load; ex_wb_en = wb; ex_rd_addr = rd;
        ex_result = res; ex_funct3 = f3; ex_addr_lo = lo;
        tick();
        ex_valid = 0;
    endtask

    task automatic respond(input logic [31:0] w);
        mem_rsp_valid = 1; mem_rsp_data = w;
        tick();
        mem_rsp_valid = 0;
    endtask

    // Literal check applied to both the DUT and the model
    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] exp);
        chk(name, dut_v, exp);
        chk({name, " model"}, mdl_v, exp);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] w;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   n;

    initial begin
        vecs[0] = '{3'b000, 2'd3, 32'h80FF1234, 32'hFFFFFF80};
        vecs[1] = '{3'b100, 2'd3, 32'h80FF1234, 32'h00000080};
        vecs[2] = '{3'b101, 2'd2, 32'h80FF1234, 32'h000080FF};
        vecs[3] = '{3'b001, 2'd2, 32'h80017FFE, 32'hFFFF8001};
        vecs[4] = '{3'b001, 2'd0, 32'h80017FFE, 32'h00007FFE};
        vecs[5] = '{3'b010, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[6] = '{3'b111, 2'd0, 32'h13572468, 32'h13572468};
        vecs[7] = '{3'b000, 2'd1, 32'h0000AB00, 32'hFFFFFFAB};

        idle_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1 chk_en = 1;
        tick();
        lit("reset regs_w_en", 32'(regs_w_en), 32'(m_wen), 32'd0);
        lit("reset rd_data", rd_data, m_data, 32'd0);
        lit("reset err_flags", 32'(err_flags), 32'(m_err), 32'd0);
        lit("reset ex_ready", 32'(ex_ready), 32'(!m_busy), 32'd1);
        tick();
        rst_n = 1;
        tick();

        // Plain ALU write-back
        issue(0, 1, 5'd5, 32'hDEADBEEF, 3'b000, 2'd0);
        lit("alu wen", 32'(regs_w_en), 32'(m_wen), 32'd1);
        lit("alu rd", 32'(rd_addr), 32'(m_rd), 32'd5);
        lit("alu data", rd_data, m_data, 32'hDEADBEEF);
        tick();
        lit("alu wen drop", 32'(regs_w_en), 32'(m_wen), 32'd0);
        lit("alu data hold", rd_data, m_data, 32'hDEADBEEF);

        // Load formatting table
        foreach (vecs[i]) begin
            issue(1, 1, 5'(10 + i), 32'h0, vecs[i].f3, vecs[i].lo);
            lit("load busy", 32'(ex_ready), 32'(!m_busy), 32'd0);
            respond(vecs[i].w);
            lit("load wen", 32'(regs_w_en), 32'(m_wen), 32'd1);
            lit("load rd", 32'(rd_addr), 32'(m_rd), 32'(10 + i));
            lit("load data", rd_data, m_data, vecs[i].exp);
            tick();
        end

        // Load then ALU op, response late; ALU op held on the bus
        issue(1, 1, 5'd20, 32'h0, 3'b010, 2'd0);
        ex_valid = 1; ex_is_load = 0; ex_wb_en = 1; ex_rd_addr = 5'd9; ex_result = 32'h12345678;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!ex_ready) n++;
            mem_rsp_valid = (i == 3);
            mem_rsp_data  = 32'h0BADF00D;
            tick();
        end
        mem_rsp_valid = 0;
        chk("b2b stall cycles", 32'(n), 32'd4);
        lit("b2b first rd", 32'(rd_addr), 32'(m_rd), 32'd20);
        lit("b2b first data", rd_data, m_data, 32'h0BADF00D);
        tick();
        ex_valid = 0;
        lit("b2b second wen", 32'(regs_w_en), 32'(m_wen), 32'd1);
        lit("b2b second rd", 32'(rd_addr), 32'(m_rd), 32'd9);
        lit("b2b second data", rd_data, m_data, 32'h12345678);
        tick();

        // Misaligned word and half loads, then a write to x0
        issue(1, 1, 5'd7, 32'h0, 3'b010, 2'd1);
        respond(32'hFFFFFFFF);
        lit("misalign wen", 32'(regs_w_en), 32'(m_wen), 32'd0);
        lit("misalign err", 32'(err_flags), 32'(m_err), 32'b001);
        lit("misalign data hold", rd_data, m_data, 32'h12345678);
        issue(1, 1, 5'd7, 32'h0, 3'b101, 2'd3);
        respond(32'hFFFFFFFF);
        lit("misalign half wen", 32'(regs_w_en), 32'(m_wen), 32'd0);
        issue(0, 1, 5'd0, 32'h55555555, 3'b000, 2'd0);
        lit("x0 wen", 32'(regs_w_en), 32'(m_wen), 32'd0);
        lit("x0 rd hold", 32'(rd_addr), 32'(m_rd), 32'd9);
        tick();

        // Timeout with no response, then a stray response
        issue(1, 1, 5'd3, 32'h0, 3'b010, 2'd0);
        n = 0;
        while (!ex_ready && n < 20) begin
            n++;
            tick();
        end
        chk("timeout cycles", 32'(n), 32'(TO));
        lit("timeout err", 32'(err_flags), 32'(m_err), 32'b101);
        respond(32'h11111111);
        lit("late rsp wen", 32'(regs_w_en), 32'(m_wen), 32'd0);
        lit("late rsp err", 32'(err_flags), 32'(m_err), 32'b111);
        tick();

        // Reset while a load is outstanding
        issue(1, 1, 5'd4, 32'h0, 3'b010, 2'd0);
        tick();
        rst_n = 0;
        #1;
        lit("midrst ready", 32'(ex_ready), 32'(!m_busy), 32'd1);
        lit("midrst mem ready", 32'(mem_rsp_ready), 32'(m_busy), 32'd0);
        lit("midrst err", 32'(err_flags), 32'(m_err), 32'd0);
        lit("midrst data", rd_data, m_data, 32'd0);
        lit("midrst rd", 32'(rd_addr), 32'(m_rd), 32'd0);
        tick();
        rst_n = 1;
        tick();
        respond(32'h22222222);
        lit("postrst wen", 32'(regs_w_en), 32'(m_wen), 32'd0);
        lit("postrst err", 32'(err_flags), 32'(m_err), 32'b010);
        tick();
        tick();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
